// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared memory bus types and arbiter state encoding
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
    } mem_read_req_t;

    typedef struct packed {
        logic              done;
        logic [DATA_W-1:0] data;
    } mem_read_rsp_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic [DATA_W-1:0] data;
    } mem_write_req_t;

    typedef struct packed {
        logic done;
    } mem_write_rsp_t;

    localparam mem_read_req_t  mem_read_req_rst  = '0;
    localparam mem_write_req_t mem_write_req_rst = '0;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_FETCH,
        ARB_BUSY_RD,
        ARB_BUSY_WR
    } arb_state_t;

    localparam arb_state_t arb_state_rst = ARB_IDLE;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_FETCH = 0;
    localparam int GNT_RD    = 1;
    localparam int GNT_WR    = 2;

endpackage

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - combinational priority and streak-override grant decision
module mem_arb_select
    import mem_arbiter_pkg::*;
(
    input  logic       fetch_en_i,
    input  logic       rd_en_i,
    input  logic       wr_en_i,
    input  logic       streak_max_i,
    output logic [2:0] grant_o
);

    // Data normally wins; fetch wins alone or once data has used its streak
    always_comb begin
        grant_o = '0;
        if (fetch_en_i && (streak_max_i || !(rd_en_i || wr_en_i))) begin
            grant_o[GNT_FETCH] = 1'b1;
        end else if (wr_en_i) begin
            grant_o[GNT_WR] = 1'b1;
        end else if (rd_en_i) begin
            grant_o[GNT_RD] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  mem_read_req_t  fetch_read_req,
    output mem_read_rsp_t  fetch_read_rsp,
    input  mem_read_req_t  data_read_req,
    output mem_read_rsp_t  data_read_rsp,
    input  mem_write_req_t data_write_req,
    output mem_write_rsp_t data_write_rsp,
    output mem_read_req_t  mem_read_req,
    input  mem_read_rsp_t  mem_read_rsp,
    output mem_write_req_t mem_write_req,
    input  mem_write_rsp_t mem_write_rsp,
    output logic           grant_fetch,
    output logic           grant_data,
    output logic           timeout_err
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam int TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    arb_state_t          state_q, state_d;
    mem_read_req_t       rd_lat_q, rd_lat_d;
    mem_write_req_t      wr_lat_q, wr_lat_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                orphan_q, orphan_d;

    logic [2:0] grant;
    logic       busy;
    logic       rd_busy;
    logic       owner_en;
    logic       down_done;
    logic       timed_out;
    logic       orphan;
    logic       deliver;

    mem_arb_select u_select (
        .fetch_en_i   (fetch_read_req.en),
        .rd_en_i      (data_read_req.en),
        .wr_en_i      (data_write_req.en),
        .streak_max_i (streak_q == STREAK_MAX),
        .grant_o      (grant)
    );

    always_comb begin
        busy     = (state_q != ARB_IDLE);
        rd_busy  = (state_q == ARB_BUSY_FETCH) || (state_q == ARB_BUSY_RD);
        owner_en = 1'b0;
        case (state_q)
            ARB_BUSY_FETCH: owner_en = fetch_read_req.en;
            ARB_BUSY_RD:    owner_en = data_read_req.en;
            ARB_BUSY_WR:    owner_en = data_write_req.en;
            default:        owner_en = 1'b0;
        endcase
        down_done = rd_busy ? mem_read_rsp.done
                            : ((state_q == ARB_BUSY_WR) && mem_write_rsp.done);
        timed_out = busy && !down_done && (timer_q == TIMER_LAST);
        // A flushed owner is treated as gone for the rest of the transaction, including this cycle
        orphan    = orphan_q || (busy && !owner_en);
        deliver   = (down_done || timed_out) && !orphan;
    end

    always_comb begin
        state_d  = state_q;
        rd_lat_d = rd_lat_q;
        wr_lat_d = wr_lat_q;
        streak_d = streak_q;
        timer_d  = timer_q;
        orphan_d = orphan_q;
        case (state_q)
            ARB_IDLE: begin
                timer_d  = '0;
                orphan_d = 1'b0;
                if (grant[GNT_FETCH]) begin
                    state_d  = ARB_BUSY_FETCH;
                    rd_lat_d = fetch_read_req;
                    streak_d = '0;
                end else if (grant[GNT_WR]) begin
                    state_d  = ARB_BUSY_WR;
                    wr_lat_d = data_write_req;
                    streak_d = streak_q + 1'b1;
                end else if (grant[GNT_RD]) begin
                    state_d  = ARB_BUSY_RD;
                    rd_lat_d = data_read_req;
                    streak_d = streak_q + 1'b1;
                end
            end
            default: begin
                orphan_d = orphan;
                if (timer_q != TIMER_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
                if (down_done || timed_out) begin
                    state_d  = ARB_IDLE;
                    timer_d  = '0;
                    orphan_d = 1'b0;
                end
            end
        endcase
        // The streak only means something while fetch is actually waiting
        if (!fetch_read_req.en) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= arb_state_rst;
            rd_lat_q <= mem_read_req_rst;
            wr_lat_q <= mem_write_req_rst;
            streak_q <= '0;
            timer_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_lat_q <= rd_lat_d;
            wr_lat_q <= wr_lat_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            orphan_q <= orphan_d;
        end
    end

    always_comb begin
        mem_read_req   = mem_read_req_rst;
        mem_write_req  = mem_write_req_rst;
        fetch_read_rsp = '0;
        data_read_rsp  = '0;
        data_write_rsp = '0;
        if (rd_busy && !timed_out) begin
            mem_read_req    = rd_lat_q;
            mem_read_req.en = 1'b1;
        end
        if ((state_q == ARB_BUSY_WR) && !timed_out) begin
            mem_write_req    = wr_lat_q;
            mem_write_req.en = 1'b1;
        end
        if (deliver) begin
            case (state_q)
                ARB_BUSY_FETCH: begin
                    fetch_read_rsp.done = 1'b1;
                    fetch_read_rsp.data = timed_out ? '0 : mem_read_rsp.data;
                end
                ARB_BUSY_RD: begin
                    data_read_rsp.done = 1'b1;
                    data_read_rsp.data = timed_out ? '0 : mem_read_rsp.data;
                end
                ARB_BUSY_WR: data_write_rsp.done = 1'b1;
                default: ;
            endcase
        end
    end

    assign grant_fetch = (state_q == ARB_BUSY_FETCH);
    assign grant_data  = (state_q == ARB_BUSY_RD) || (state_q == ARB_BUSY_WR);
    assign timeout_err = timed_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    mem_read_req_t  fetch_read_req;
    mem_read_rsp_t  fetch_read_rsp;
    mem_read_req_t  data_read_req;
    mem_read_rsp_t  data_read_rsp;
    mem_write_req_t data_write_req;
    mem_write_rsp_t data_write_rsp;
    mem_read_req_t  mem_read_req;
    mem_read_rsp_t  mem_read_rsp;
    mem_write_req_t mem_write_req;
    mem_write_rsp_t mem_write_rsp;
    logic           grant_fetch;
    logic           grant_data;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_read_req (fetch_read_req),
        .fetch_read_rsp (fetch_read_rsp),
        .data_read_req  (data_read_req),
        .data_read_rsp  (data_read_rsp),
        .data_write_req (data_write_req),
        .data_write_rsp (data_write_rsp),
        .mem_read_req   (mem_read_req),
        .mem_read_rsp   (mem_read_rsp),
        .mem_write_req  (mem_write_req),
        .mem_write_rsp  (mem_write_rsp),
        .grant_fetch    (grant_fetch),
        .grant_data     (grant_data),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        fetch_read_req = '0;
        data_read_req  = '0;
        data_write_req = '0;
        mem_read_rsp   = '0;
        mem_write_rsp  = '0;
        #2;
        checks++; if (mem_read_req !== '0) begin errors++; $display("FAIL reset_mem_rd: got %h want 0", mem_read_req); end
        checks++; if (mem_write_req !== '0) begin errors++; $display("FAIL reset_mem_wr: got %h want 0", mem_write_req); end
        checks++; if ({fetch_read_rsp, data_read_rsp, data_write_rsp} !== '0) begin errors++; $display("FAIL reset_rsp: got %h want 0", {fetch_read_rsp, data_read_rsp, data_write_rsp}); end
        checks++; if ({grant_fetch, grant_data, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {grant_fetch, grant_data, timeout_err}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetch_only();
        @(negedge clk);
        fetch_read_req = '{en: 1'b1, addr: 32'h100, size: 2'd2};
        #1;
        checks++; if (grant_fetch !== 1'b0) begin errors++; $display("FAIL t1_idle_grant: got %b want 0", grant_fetch); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 2) fetch_read_req.addr = 32'h200;
            if (k == 3) mem_read_rsp = '{done: 1'b1, data: 32'hDEADBEEF};
            #1;
            checks++; if (grant_fetch !== 1'b1) begin errors++; $display("FAIL t1_grant_c%0d: got %b want 1", k, grant_fetch); end
            checks++; if (mem_read_req.en !== 1'b1 || mem_read_req.addr !== 32'h100) begin errors++; $display("FAIL t1_mem_req_c%0d: got en=%b addr=%h want en=1 addr=100", k, mem_read_req.en, mem_read_req.addr); end
            if (k < 3) begin
                checks++; if (fetch_read_rsp.done !== 1'b0) begin errors++; $display("FAIL t1_early_done_c%0d: got %b want 0", k, fetch_read_rsp.done); end
            end
        end
        checks++; if (fetch_read_rsp.done !== 1'b1 || fetch_read_rsp.data !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_rsp: got done=%b data=%h want done=1 data=deadbeef", fetch_read_rsp.done, fetch_read_rsp.data); end
        checks++; if (data_read_rsp !== '0) begin errors++; $display("FAIL t1_nonowner: got %h want 0", data_read_rsp); end
        @(negedge clk);
        fetch_read_req = '0;
        mem_read_rsp   = '0;
        #1;
        checks++; if (grant_fetch !== 1'b0 || mem_read_req.en !== 1'b0) begin errors++; $display("FAIL t1_bubble: got grant=%b en=%b want 0 0", grant_fetch, mem_read_req.en); end
    endtask

    task automatic test_streak();
        logic [5:0] exp_fetch;
        logic [5:0] got;
        int n;
        n = 0;
        got = '0;
        exp_fetch = 6'b010000;
        @(negedge clk);
        fetch_read_req = '{en: 1'b1, addr: 32'h500, size: 2'd2};
        data_write_req = '{en: 1'b1, addr: 32'h600, size: 2'd2, data: 32'h11112222};
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            #1;
            mem_read_rsp  = '{done: mem_read_req.en, data: 32'h0};
            mem_write_rsp = '{done: mem_write_req.en};
            if (grant_fetch || grant_data) begin
                got[n] = grant_fetch;
                n++;
            end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL t2_grant_count: got %0d want 6", n); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== exp_fetch[i]) begin errors++; $display("FAIL t2_grant_%0d: got fetch=%b want fetch=%b", i, got[i], exp_fetch[i]); end
        end
        @(negedge clk);
        fetch_read_req = '0;
        data_write_req = '0;
        mem_read_rsp   = '0;
        mem_write_rsp  = '0;
    endtask

    task automatic test_write_wins();
        @(negedge clk);
        data_read_req  = '{en: 1'b1, addr: 32'h40, size: 2'd2};
        data_write_req = '{en: 1'b1, addr: 32'h40, size: 2'd2, data: 32'h00001234};
        @(negedge clk);
        mem_write_rsp = '{done: 1'b1};
        mem_read_rsp  = '{done: 1'b1, data: 32'h77777777};
        #1;
        checks++; if (mem_write_req.en !== 1'b1 || mem_read_req.en !== 1'b0) begin errors++; $display("FAIL t3_en: got wr=%b rd=%b want 1 0", mem_write_req.en, mem_read_req.en); end
        checks++; if (mem_write_req.addr !== 32'h40 || mem_write_req.data !== 32'h1234) begin errors++; $display("FAIL t3_wr_payload: got addr=%h data=%h want 40 1234", mem_write_req.addr, mem_write_req.data); end
        checks++; if (data_write_rsp.done !== 1'b1 || data_read_rsp.done !== 1'b0) begin errors++; $display("FAIL t3_rsp: got wr_done=%b rd_done=%b want 1 0", data_write_rsp.done, data_read_rsp.done); end
        @(negedge clk);
        data_read_req  = '0;
        data_write_req = '0;
        mem_write_rsp  = '0;
        mem_read_rsp   = '0;
        #1;
        checks++; if (data_read_rsp.done !== 1'b0 || grant_data !== 1'b0) begin errors++; $display("FAIL t3_after: got rd_done=%b grant=%b want 0 0", data_read_rsp.done, grant_data); end
    endtask

    task automatic test_orphan();
        @(negedge clk);
        fetch_read_req = '{en: 1'b1, addr: 32'h180, size: 2'd2};
        @(negedge clk);
        #1;
        checks++; if (grant_fetch !== 1'b1) begin errors++; $display("FAIL t4_grant: got %b want 1", grant_fetch); end
        @(negedge clk);
        fetch_read_req.en = 1'b0;
        #1;
        checks++; if (mem_read_req.en !== 1'b1 || fetch_read_rsp.done !== 1'b0) begin errors++; $display("FAIL t4_flushed_run: got en=%b done=%b want 1 0", mem_read_req.en, fetch_read_rsp.done); end
        @(negedge clk);
        mem_read_rsp = '{done: 1'b1, data: 32'hABCD0001};
        #1;
        checks++; if (fetch_read_rsp !== '0) begin errors++; $display("FAIL t4_discard: got %h want 0", fetch_read_rsp); end
        @(negedge clk);
        mem_read_rsp   = '0;
        #1;
        checks++; if (grant_fetch !== 1'b0 || mem_read_req.en !== 1'b0) begin errors++; $display("FAIL t4_idle: got grant=%b en=%b want 0 0", grant_fetch, mem_read_req.en); end
        fetch_read_req = '{en: 1'b1, addr: 32'h1C0, size: 2'd2};
        @(negedge clk);
        mem_read_rsp = '{done: 1'b1, data: 32'h0000CAFE};
        #1;
        checks++; if (fetch_read_rsp.done !== 1'b1 || fetch_read_rsp.data !== 32'hCAFE) begin errors++; $display("FAIL t4_next_fetch: got done=%b data=%h want 1 cafe", fetch_read_rsp.done, fetch_read_rsp.data); end
        @(negedge clk);
        fetch_read_req = '0;
        mem_read_rsp   = '0;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        data_read_req = '{en: 1'b1, addr: 32'h80, size: 2'd2};
        mem_read_rsp  = '{done: 1'b0, data: 32'h55555555};
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            if (k < 8) begin
                checks++; if (data_read_rsp.done !== 1'b0 || timeout_err !== 1'b0 || mem_read_req.en !== 1'b1) begin errors++; $display("FAIL t5_wait_c%0d: got done=%b err=%b en=%b want 0 0 1", k, data_read_rsp.done, timeout_err, mem_read_req.en); end
            end
        end
        checks++; if (data_read_rsp.done !== 1'b1 || data_read_rsp.data !== 32'h0) begin errors++; $display("FAIL t5_abort_rsp: got done=%b data=%h want 1 0", data_read_rsp.done, data_read_rsp.data); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL t5_err_pulse: got %b want 1", timeout_err); end
        @(negedge clk);
        #1;
        checks++; if (timeout_err !== 1'b0 || mem_read_req.en !== 1'b0 || grant_data !== 1'b0) begin errors++; $display("FAIL t5_after: got err=%b en=%b grant=%b want 0 0 0", timeout_err, mem_read_req.en, grant_data); end
        data_read_req = '0;
        mem_read_rsp  = '{done: 1'b1, data: 32'h99999999};
        @(negedge clk);
        #1;
        checks++; if ({fetch_read_rsp, data_read_rsp, grant_fetch, grant_data} !== '0) begin errors++; $display("FAIL t5_spurious: got %h want 0", {fetch_read_rsp, data_read_rsp, grant_fetch, grant_data}); end
        mem_read_rsp = '0;
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        data_write_req = '{en: 1'b1, addr: 32'h300, size: 2'd2, data: 32'hFEEDF00D};
        @(negedge clk);
        #1;
        checks++; if (mem_write_req.en !== 1'b1) begin errors++; $display("FAIL t6_busy: got %b want 1", mem_write_req.en); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (mem_write_req.en !== 1'b0 || grant_data !== 1'b0) begin errors++; $display("FAIL t6_async: got en=%b grant=%b want 0 0", mem_write_req.en, grant_data); end
        @(negedge clk);
        data_write_req = '0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({grant_fetch, grant_data, mem_write_req.en, data_write_rsp.done} !== 4'b0000) begin errors++; $display("FAIL t6_after: got %b want 0000", {grant_fetch, grant_data, mem_write_req.en, data_write_rsp.done}); end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_streak();
        test_write_wins();
        test_orphan();
        test_timeout();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
